// File: rtl/countdown_timer_mux.sv
// countdown_timer_mux: BCD countdown timer with multiplexed 7-segment display
// for the bomb-dismantlement game.
//   clk, rst      clock, asynchronous active-high reset
//   start         pulse, loads load_val and starts counting (IDLE only)
//   pause         level, holds the countdown
//   success       pulse, bomb defused, freezes the count
//   clear         synchronous return to IDLE from any state
//   load_val      BCD start value, digit 0 in [3:0]
//   count_bcd     current BCD count
//   running/expired/defused  state flags (RUN / EXPLODED / DEFUSED)
//   cat           active-low digit select, bit i = digit i
//   seg           active-high segments {dp,g,f,e,d,c,b,a}
// Optional feature macro: BLINK_EN (blink the display in the terminal states).
module countdown_timer_mux #(
   parameter int unsigned DIGITS   = 2,
   parameter int unsigned TICK_DIV = 1200,
   parameter int unsigned SCAN_DIV = 22
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  pause,
   input  logic                  success,
   input  logic                  clear,
   input  logic [4*DIGITS-1:0]   load_val,
   output logic [4*DIGITS-1:0]   count_bcd,
   output logic                  running,
   output logic                  expired,
   output logic                  defused,
   output logic [7:0]            cat,
   output logic [7:0]            seg
);

   localparam int unsigned CW = 4 * DIGITS;
   localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
   localparam logic [DW-1:0] DIG_LAST  = DW'(DIGITS - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_RUN, S_PAUSED, S_DEFUSED, S_EXPLODED
   } state_t;

   state_t          state, state_next;
   logic [CW-1:0]   count_next;
   logic [TW-1:0]   tick_cnt, tick_next;
   logic [SW-1:0]   scan_cnt;
   logic [DW-1:0]   digit_idx;
   logic [CW-1:0]   load_clamped, count_dec, disp_src;
   logic [3:0]      disp_nib;
   logic            tick_wrap;
`ifdef BLINK_EN
   logic            blink_off, blink_next;
`endif

   // Saturate any non-decimal nibble to 9
   function automatic logic [CW-1:0] clamp_bcd(input logic [CW-1:0] v);
      logic [CW-1:0] r;
      r = v;
      for (int unsigned i = 0; i < DIGITS; i++)
         if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
      return r;
   endfunction

   // BCD decrement with ripple borrow; caller guarantees a nonzero operand
   function automatic logic [CW-1:0] bcd_dec(input logic [CW-1:0] v);
      logic [CW-1:0] r;
      logic          borrow;
      r      = v;
      borrow = 1'b1;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (borrow) begin
            if (v[4*i +: 4] == 4'd0) begin
               r[4*i +: 4] = 4'd9;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] - 4'd1;
               borrow      = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [7:0] seg_decode(input logic [3:0] d);
      case (d)
         4'd0:    return 8'h3F;
         4'd1:    return 8'h06;
         4'd2:    return 8'h5B;
         4'd3:    return 8'h4F;
         4'd4:    return 8'h66;
         4'd5:    return 8'h6D;
         4'd6:    return 8'h7D;
         4'd7:    return 8'h07;
         4'd8:    return 8'h7F;
         4'd9:    return 8'h6F;
         default: return 8'h00;
      endcase
   endfunction

   assign load_clamped = clamp_bcd(load_val);
   assign count_dec    = bcd_dec(count_bcd);
   assign tick_wrap    = (tick_cnt == TICK_LAST);

   // Next-state, count and tick logic; priority clear > success > pause > step
   always_comb begin
      state_next = state;
      count_next = count_bcd;
      tick_next  = tick_cnt;
`ifdef BLINK_EN
      blink_next = blink_off;
`endif
      if (clear) begin
         state_next = S_IDLE;
         count_next = '0;
         tick_next  = '0;
`ifdef BLINK_EN
         blink_next = 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               tick_next = '0;
               if (start) begin
                  count_next = load_clamped;
                  state_next = (load_clamped == '0) ? S_EXPLODED : S_RUN;
               end
            end
            S_RUN: begin
               if (success) begin
                  state_next = S_DEFUSED;
                  tick_next  = '0;
               end else if (pause) begin
                  state_next = S_PAUSED;
               end else if (tick_wrap) begin
                  tick_next  = '0;
                  count_next = count_dec;
                  if (count_dec == '0) state_next = S_EXPLODED;
               end else begin
                  tick_next = tick_cnt + TW'(1);
               end
            end
            S_PAUSED: begin
               if (success) begin
                  state_next = S_DEFUSED;
                  tick_next  = '0;
               end else if (!pause) begin
                  state_next = S_RUN;
               end
            end
            S_DEFUSED, S_EXPLODED: begin
`ifdef BLINK_EN
               // Terminal states are entered with tick=0 and lit phase
               if (tick_wrap) begin
                  tick_next  = '0;
                  blink_next = ~blink_off;
               end else begin
                  tick_next = tick_cnt + TW'(1);
               end
`else
               tick_next = '0;
`endif
            end
            default: state_next = S_IDLE;
         endcase
      end
   end

   // Display source nibble for the currently scanned digit
   always_comb begin
      disp_src = (state == S_IDLE) ? load_clamped : count_bcd;
      disp_nib = 4'd0;
      for (int unsigned i = 0; i < DIGITS; i++)
         if (digit_idx == DW'(i)) disp_nib = disp_src[4*i +: 4];
   end

   // State, count and flag registers; flags track the state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         count_bcd <= '0;
         tick_cnt  <= '0;
         running   <= 1'b0;
         expired   <= 1'b0;
         defused   <= 1'b0;
`ifdef BLINK_EN
         blink_off <= 1'b0;
`endif
      end else begin
         state     <= state_next;
         count_bcd <= count_next;
         tick_cnt  <= tick_next;
         running   <= (state_next == S_RUN);
         expired   <= (state_next == S_EXPLODED);
         defused   <= (state_next == S_DEFUSED);
`ifdef BLINK_EN
         blink_off <= blink_next;
`endif
      end
   end

   // Digit scan; cat and seg are registered together from digit_idx
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scan_cnt  <= '0;
         digit_idx <= '0;
         cat       <= 8'hFF;
         seg       <= 8'h00;
      end else begin
         if (scan_cnt == SCAN_LAST) begin
            scan_cnt  <= '0;
            digit_idx <= (digit_idx == DIG_LAST) ? '0 : digit_idx + DW'(1);
         end else begin
            scan_cnt <= scan_cnt + SW'(1);
         end
         cat <= ~(8'(1) << digit_idx);
`ifdef BLINK_EN
         seg <= blink_off ? 8'h00 : seg_decode(disp_nib);
`else
         seg <= seg_decode(disp_nib);
`endif
      end
   end

endmodule
